eth_frame_builder: RTL and testbench
====================================

# eth_frame_builder

Byte-level Ethernet frame builder that feeds the RMII dibit transmitter. It accepts a payload byte stream and emits a complete frame one byte at a time over a ready/valid handshake: preamble, SFD, a fixed header, the payload, zero padding and the CRC-32 FCS. It then enforces the inter-packet gap before it accepts the next frame. The downstream serializer shifts each byte out LSB first, two bits per clock, so it pulls at most one byte every 4 clocks.

## Interface
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC; bytes are emitted MSB byte first.
- SRC_MAC, 48'h020000000001, source MAC; bytes are emitted MSB byte first.
- ETHERTYPE, 16'h0800, type field; high byte is emitted first.
- MAX_PAYLOAD, 1500, maximum payload bytes per frame.
- IFG_CYCLES, 48, idle clocks after the last FCS byte (12 bytes × 4 clocks).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  starts a frame when sampled high in IDLE; ignored in every other state.
- busy  out  1  high from the cycle after start until the IFG expires.
- pl_data  in  8  payload byte.
- pl_valid  in  1  pl_data is valid.
- pl_last  in  1  marks the final payload byte.
- pl_ready  out  1  the builder accepts a payload byte this cycle.
- tx_data  out  8  frame byte to the serializer.
- tx_valid  out  1  tx_data is valid.
- tx_last  out  1  high with the final FCS byte.
- tx_ready  in  1  the serializer takes tx_data this cycle.
- err_overlong  out  1  one-cycle pulse when a payload is truncated at MAX_PAYLOAD.

## Operation
- States: IDLE, PRE, SFD, HDR, PAY, PAD, FCS, DRAIN, IFG.
- IDLE: start=1 moves to PRE. The CRC register is set to 32'hFFFFFFFF and the byte counter to 0.
- PRE: emits 7 bytes of 8'h55, then moves to SFD.
- SFD: emits 8'hD5, then moves to HDR.
- HDR: emits 14 bytes: DST_MAC, SRC_MAC, ETHERTYPE.
- PAY: forwards each accepted payload byte to tx_data, one byte per transfer.
  - pl_ready = (state==PAY) && (!tx_valid || tx_ready).
  - An accepted byte with pl_last=1 ends the payload.
  - When payload count is below 46 the next state is PAD; otherwise it is FCS.
- PAD: emits 8'h00 until the payload-plus-pad count reaches 46.
- FCS:
  - CRC is the reflected CRC-32: polynomial 32'hEDB88320, LSB-first update, one byte per clock, 8 unrolled steps.
  - The CRC covers every byte from HDR through PAD.
  - FCS = ~crc, emitted crc[7:0] first, 4 bytes total. tx_last is asserted on the 4th byte.
- Overlong payload:
  - The MAX_PAYLOAD-th accepted byte without pl_last is treated as the last payload byte.
  - err_overlong pulses in the cycle that byte is accepted, and the state moves to FCS.
  - After FCS the state is DRAIN instead of IFG.
- DRAIN: pl_ready=1. Input bytes are discarded until a byte with pl_last=1 is accepted, then the state moves to IFG.
- IFG: counts IFG_CYCLES clocks from the final FCS transfer or the end of DRAIN, whichever is later, then returns to IDLE.
- Byte counter is 11 bits wide. Payload count saturates at MAX_PAYLOAD.

## Timing
- Reset values: tx_data=0, tx_valid=0, tx_last=0, pl_ready=0, busy=0, err_overlong=0, state=IDLE.
- Asserting rst_n mid-frame aborts immediately with no FCS and no IFG wait.
- Output register:
  - tx_data, tx_valid and tx_last are registered.
  - A transfer occurs when tx_valid && tx_ready.
  - While tx_valid=1 && tx_ready=0, tx_data and tx_last hold stable.
- Latency:
  - start sampled in IDLE at cycle N gives tx_valid=1 with 8'h55 at cycle N+1.
  - A payload byte accepted at cycle N appears on tx_data at cycle N+1.
- With tx_ready held at 1, back-to-back bytes are emitted every clock. Payload stalls only on pl_valid=0.
- The CRC updates in the cycle a byte is loaded into the output register, so the FCS byte is ready with no bubble after the last payload or pad byte.
- start is ignored whenever busy=1, including the cycle busy falls.

## Test plan
- Reset:
  - Drive rst_n=0 while pl_valid=1 and tx_ready=1.
  - Required: all outputs 0; no tx_valid until start.
- 46-byte payload 8'h00..8'h2D, tx_ready=1:
  - Required: exactly 72 bytes: 55×7, D5, FF×6, 02 00 00 00 00 01, 08 00, payload, 4 FCS.
  - The reflected CRC register run over HDR..FCS ends at residue 32'hDEBB20E3.
  - tx_last is high only on byte 72.
  - busy falls 48 clocks after the last transfer.
- 1-byte payload 8'hAB:
  - Required: 45 bytes of 8'h00 pad, total frame 72 bytes, FCS equal to the model.
- Serializer backpressure, tx_ready high 1 cycle in 4:
  - Required: no byte lost or duplicated; tx_data stable across stalls; same 72-byte frame as the unstalled case.
- Overlong, 1600-byte payload with pl_last on byte 1600:
  - Required: frame is 8+14+1500+4 = 1526 bytes.
  - err_overlong pulses once, on acceptance of byte 1500.
  - The remaining 100 bytes are accepted and dropped.
  - busy stays high until IFG completes.
- start re-pulsed mid-payload and during IFG:
  - Required: ignored, with no frame corruption.
- rst_n pulsed low mid-PAY, then start:
  - Required: tx_valid=0 immediately at reset; the new frame is complete and correct.

Source files
------------

// File: rtl/eth_frame_builder.sv
// eth_frame_builder: assembles a complete Ethernet frame byte by byte
// (preamble, SFD, fixed header, payload, zero pad, CRC-32 FCS) for the RMII
// dibit serializer, then holds off the next frame for the inter-packet gap.
module eth_frame_builder #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE   = 16'h0800,
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned IFG_CYCLES  = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    input  logic       pl_last,
    output logic       pl_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_last,
    input  logic       tx_ready,
    output logic       err_overlong
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        PRE   = 4'd1,
        SFD   = 4'd2,
        HDR   = 4'd3,
        PAY   = 4'd4,
        PAD   = 4'd5,
        FCS   = 4'd6,
        DRAIN = 4'd7,
        IFG   = 4'd8
    } state_t;

    localparam logic [111:0] HDR_C      = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [10:0]  MAX_LAST_C = 11'(MAX_PAYLOAD - 1);
    localparam logic [10:0]  MIN_PL_C   = 11'd46;
    localparam logic [5:0]   IFG_LAST_C = 6'(IFG_CYCLES - 1);
    localparam logic [31:0]  CRC_POLY_C = 32'hEDB8_8320;

    // Reflected CRC-32, one byte consumed LSB first in 8 unrolled steps.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [31:0] crc_v;
        crc_v = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0] ^ data_in[i]) begin
                crc_v = {1'b0, crc_v[31:1]} ^ CRC_POLY_C;
            end else begin
                crc_v = {1'b0, crc_v[31:1]};
            end
        end
        return crc_v;
    endfunction

    // FCS is the inverted CRC, least significant byte sent first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc_in,
                                            input logic [1:0]  idx);
        logic [31:0] fcs_v;
        logic [7:0]  byte_v;
        fcs_v = ~crc_in;
        case (idx)
            2'd0:    byte_v = fcs_v[7:0];
            2'd1:    byte_v = fcs_v[15:8];
            2'd2:    byte_v = fcs_v[23:16];
            default: byte_v = fcs_v[31:24];
        endcase
        return byte_v;
    endfunction

    state_t        state_r, state_s;
    logic [10:0]   cnt_r, cnt_s;
    logic [31:0]   crc_r, crc_s;
    logic [111:0]  hdr_r, hdr_s;
    logic [5:0]    ifg_r, ifg_s;
    logic          ovl_r, ovl_s;
    logic [7:0]    tx_data_s;
    logic          tx_valid_s, tx_last_s, busy_s, err_s;
    logic          load_s, pl_ready_s;

    // The output register can take a new byte when empty or being drained.
    assign load_s     = !tx_valid || tx_ready;
    assign pl_ready_s = ((state_r == PAY) && load_s) || (state_r == DRAIN);
    assign pl_ready   = pl_ready_s;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        crc_s      = crc_r;
        hdr_s      = hdr_r;
        ifg_s      = ifg_r;
        ovl_s      = ovl_r;
        tx_data_s  = tx_data;
        tx_valid_s = tx_valid & ~tx_ready;
        tx_last_s  = tx_last & ~(tx_valid & tx_ready);
        busy_s     = busy;
        err_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = PRE;
                    cnt_s      = 11'd1;
                    crc_s      = 32'hFFFF_FFFF;
                    hdr_s      = HDR_C;
                    ovl_s      = 1'b0;
                    busy_s     = 1'b1;
                    tx_data_s  = 8'h55;
                    tx_valid_s = 1'b1;
                    tx_last_s  = 1'b0;
                end else begin
                    busy_s = 1'b0;
                end
            end
            PRE: begin
                if (load_s) begin
                    tx_data_s  = 8'h55;
                    tx_valid_s = 1'b1;
                    cnt_s      = cnt_r + 11'd1;
                    if (cnt_r == 11'd6) begin
                        state_s = SFD;
                    end else begin
                        state_s = PRE;
                    end
                end else begin
                    state_s = PRE;
                end
            end
            SFD: begin
                if (load_s) begin
                    tx_data_s  = 8'hD5;
                    tx_valid_s = 1'b1;
                    cnt_s      = 11'd0;
                    state_s    = HDR;
                end else begin
                    state_s = SFD;
                end
            end
            HDR: begin
                if (load_s) begin
                    tx_data_s  = hdr_r[111:104];
                    tx_valid_s = 1'b1;
                    hdr_s      = {hdr_r[103:0], 8'h00};
                    crc_s      = crc32_byte(crc_r, hdr_r[111:104]);
                    if (cnt_r == 11'd13) begin
                        state_s = PAY;
                        cnt_s   = 11'd0;
                    end else begin
                        cnt_s = cnt_r + 11'd1;
                    end
                end else begin
                    state_s = HDR;
                end
            end
            PAY: begin
                if (pl_valid && pl_ready_s) begin
                    tx_data_s  = pl_data;
                    tx_valid_s = 1'b1;
                    crc_s      = crc32_byte(crc_r, pl_data);
                    if (pl_last || (cnt_r == MAX_LAST_C)) begin
                        // Hitting the size limit without pl_last truncates here.
                        err_s = ~pl_last;
                        ovl_s = ~pl_last;
                        if ((cnt_r + 11'd1) < MIN_PL_C) begin
                            state_s = PAD;
                            cnt_s   = cnt_r + 11'd1;
                        end else begin
                            state_s = FCS;
                            cnt_s   = 11'd0;
                        end
                    end else begin
                        cnt_s = cnt_r + 11'd1;
                    end
                end else begin
                    state_s = PAY;
                end
            end
            PAD: begin
                if (load_s) begin
                    tx_data_s  = 8'h00;
                    tx_valid_s = 1'b1;
                    crc_s      = crc32_byte(crc_r, 8'h00);
                    if (cnt_r == (MIN_PL_C - 11'd1)) begin
                        state_s = FCS;
                        cnt_s   = 11'd0;
                    end else begin
                        cnt_s = cnt_r + 11'd1;
                    end
                end else begin
                    state_s = PAD;
                end
            end
            FCS: begin
                if (load_s) begin
                    tx_data_s  = fcs_byte(crc_r, cnt_r[1:0]);
                    tx_valid_s = 1'b1;
                    cnt_s      = cnt_r + 11'd1;
                    if (cnt_r == 11'd3) begin
                        tx_last_s = 1'b1;
                        ifg_s     = 6'd0;
                        state_s   = ovl_r ? DRAIN : IFG;
                    end else begin
                        tx_last_s = 1'b0;
                    end
                end else begin
                    state_s = FCS;
                end
            end
            DRAIN: begin
                // Swallow the rest of a truncated payload.
                if (pl_valid && pl_last) begin
                    state_s = IFG;
                    ifg_s   = 6'd0;
                end else begin
                    state_s = DRAIN;
                end
            end
            IFG: begin
                // The gap only runs once the final FCS byte has left.
                if (!tx_valid) begin
                    if (ifg_r == IFG_LAST_C) begin
                        state_s = IDLE;
                        busy_s  = 1'b0;
                    end else begin
                        ifg_s = ifg_r + 6'd1;
                    end
                end else begin
                    ifg_s = ifg_r;
                end
            end
            default: begin
                state_s    = IDLE;
                busy_s     = 1'b0;
                tx_valid_s = 1'b0;
                tx_last_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 11'd0;
            crc_r        <= 32'hFFFF_FFFF;
            hdr_r        <= HDR_C;
            ifg_r        <= 6'd0;
            ovl_r        <= 1'b0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            tx_last      <= 1'b0;
            busy         <= 1'b0;
            err_overlong <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            crc_r        <= crc_s;
            hdr_r        <= hdr_s;
            ifg_r        <= ifg_s;
            ovl_r        <= ovl_s;
            tx_data      <= tx_data_s;
            tx_valid     <= tx_valid_s;
            tx_last      <= tx_last_s;
            busy         <= busy_s;
            err_overlong <= err_s;
        end
    end

endmodule

// File: tb/tb_eth_frame_builder.sv
// Testbench for eth_frame_builder: table of frame scenarios driven through a
// payload driver, with a scoreboard of expected tx bytes checked by a monitor.
module tb_eth_frame_builder;

    logic       clk, rst_n, start, busy;
    logic [7:0] pl_data;
    logic       pl_valid, pl_last, pl_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last, tx_ready, err_overlong;

    eth_frame_builder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .err_overlong(err_overlong)
    );

    typedef struct packed { logic [7:0] d; logic l; } exp_t;
    typedef struct {
        int         len;
        logic [7:0] base;
        bit         bp;
        bit         restart;
        int         exp_bytes;
        int         exp_err;
    } vec_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          bp_on = 1'b0;
    int          nbytes, acc_cnt, err_seen, err_pos, last_cnt, ref_edge;
    logic [31:0] rx_crc;
    vec_t        vecs[9];

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serializer model: ready every clock, or one clock in four.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = bp_on ? ((cyc % 4) == 0) : 1'b1;
        end
    end

    // Monitor: sampled on the falling edge, sees what the next rising edge will see.
    initial begin
        exp_t       e;
        bit         stall_prev = 1'b0;
        logic [7:0] held_d = 8'h00;
        logic       held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    n_tests++;
                    if (!tx_valid || tx_data !== held_d || tx_last !== held_l) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%0b d=%02h l=%0b, required v=1 d=%02h l=%0b",
                                 tx_valid, tx_data, tx_last, held_d, held_l);
                    end
                end
                stall_prev = tx_valid && !tx_ready;
                held_d = tx_data;
                held_l = tx_last;
                if (err_overlong) begin
                    err_seen++;
                    err_pos = acc_cnt;
                end
                if (pl_valid && pl_ready) begin
                    acc_cnt++;
                    if (pl_last && (cyc + 1) > ref_edge) ref_edge = cyc + 1;
                end
                if (tx_valid && tx_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_byte: got %02h at byte %0d, required none", tx_data, nbytes);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data !== e.d || tx_last !== e.l) begin
                            n_fail++;
                            $display("FAIL tx_byte[%0d]: got %02h last=%0b, required %02h last=%0b",
                                     nbytes, tx_data, tx_last, e.d, e.l);
                        end
                    end
                    if (nbytes >= 8) rx_crc = crc_upd(rx_crc, tx_data);
                    if (tx_last) begin
                        last_cnt++;
                        if ((cyc + 1) > ref_edge) ref_edge = cyc + 1;
                    end
                    nbytes++;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Drives one frame; abort_at >= 0 resets the DUT before that payload byte.
    task automatic run_frame(input int len, input logic [7:0] base, input bit bp,
                             input bit restart, input int abort_at,
                             input int exp_bytes, input int exp_err);
        int           eff, guard;
        bit           acc;
        logic [31:0]  crc, fcs;
        logic [111:0] hdr;
        logic [7:0]   b;
        eff = (len > 1500) ? 1500 : len;
        exp_q.delete();
        nbytes = 0; acc_cnt = 0; err_seen = 0; err_pos = 0; last_cnt = 0; ref_edge = 0;
        rx_crc = 32'hFFFFFFFF;
        bp_on = bp;
        for (int i = 0; i < 7; i++) push_exp(8'h55, 1'b0);
        push_exp(8'hD5, 1'b0);
        crc = 32'hFFFFFFFF;
        hdr = {48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800};
        for (int i = 0; i < 14; i++) begin
            b = hdr[111 - 8*i -: 8];
            push_exp(b, 1'b0);
            crc = crc_upd(crc, b);
        end
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        @(negedge clk);
        check("first_byte_latency", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h55});
        check("busy_after_start", {31'h0, busy}, 32'h1);
        for (int i = 0; i < len; i++) begin
            if (abort_at >= 0 && i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_outputs", {19'h0, tx_data, tx_valid, tx_last, pl_ready, busy, err_overlong},
                      32'h0);
                @(negedge clk);
                pl_valid = 1'b0; pl_last = 1'b0; start = 1'b0;
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end
            pl_data  = base + 8'(i);
            pl_valid = 1'b1;
            pl_last  = (i == len - 1);
            start    = restart && (i == len / 2);
            guard = 0;
            do begin
                @(negedge clk);
                acc = pl_ready;
                guard++;
            end while (!acc && guard < 2000);
            if (!acc) begin
                check("payload_accept_timeout", 32'(i), 32'(len));
                break;
            end
            if (i < eff) begin
                push_exp(pl_data, 1'b0);
                crc = crc_upd(crc, pl_data);
            end
            if (i == eff - 1) begin
                for (int p = eff; p < 46; p++) begin
                    push_exp(8'h00, 1'b0);
                    crc = crc_upd(crc, 8'h00);
                end
                fcs = ~crc;
                for (int k = 0; k < 4; k++) push_exp(fcs[8*k +: 8], k == 3);
            end
            @(posedge clk); #2;
        end
        pl_valid = 1'b0; pl_last = 1'b0; start = 1'b0;
        if (restart) begin
            guard = 0;
            while (last_cnt == 0 && guard < 5000) begin @(negedge clk); guard++; end
            @(posedge clk); #2; start = 1'b1;
            @(posedge clk); #2; start = 1'b0;
        end
        guard = 0;
        while (busy && guard < 20000) begin @(negedge clk); guard++; end
        check("busy_fall_timeout", {31'h0, busy}, 32'h0);
        if (!busy) check("ifg_gap", 32'(cyc - ref_edge), 32'd48);
        repeat (4) @(negedge clk);
        check("idle_after_ifg", {30'h0, tx_valid, busy}, 32'h0);
        check("frame_bytes", 32'(nbytes), 32'(exp_bytes));
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("tx_last_count", 32'(last_cnt), 32'h1);
        check("err_pulses", 32'(err_seen), 32'(exp_err));
        if (exp_err > 0) check("err_position", 32'(err_pos), 32'd1500);
        check("payload_accepted", 32'(acc_cnt), 32'(len));
        check("crc_residue", rx_crc, 32'hDEBB20E3);
        bp_on = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        pl_data = 8'hA5; pl_valid = 1'b1; pl_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'h0, tx_data, tx_valid, tx_last, pl_ready, busy, err_overlong}, 32'h0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_tx_without_start", {30'h0, tx_valid, busy}, 32'h0);
        end
        pl_valid = 1'b0;

        vecs[0] = '{46,   8'h00, 1'b0, 1'b0, 72,   0};
        vecs[1] = '{1,    8'hAB, 1'b0, 1'b0, 72,   0};
        vecs[2] = '{46,   8'h00, 1'b1, 1'b0, 72,   0};
        vecs[3] = '{60,   8'h10, 1'b0, 1'b0, 86,   0};
        vecs[4] = '{1600, 8'h00, 1'b0, 1'b0, 1526, 1};
        vecs[5] = '{45,   8'h33, 1'b1, 1'b0, 72,   0};
        vecs[6] = '{1500, 8'h07, 1'b0, 1'b0, 1526, 0};
        vecs[7] = '{47,   8'hC0, 1'b0, 1'b0, 73,   0};
        vecs[8] = '{50,   8'h5A, 1'b0, 1'b1, 76,   0};
        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].len, vecs[v].base, vecs[v].bp, vecs[v].restart, -1,
                      vecs[v].exp_bytes, vecs[v].exp_err);
        end

        // Reset mid-payload, then a clean frame must follow.
        run_frame(46, 8'h20, 1'b0, 1'b0, 10, 72, 0);
        repeat (3) @(negedge clk);
        check("post_abort_idle", {30'h0, tx_valid, busy}, 32'h0);
        run_frame(46, 8'h00, 1'b0, 1'b0, -1, 72, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
